// File: rtl/board_state_writer.sv
// board_state_writer: Connect Four game-state owner.
// Maintains the 7x6 board, cursor column, turn colour, move count and
// board-full flag from debounced single-cycle player commands.
// Optional build macro DROP_ANIM_EN: when defined, a dropped piece enters at
// the top row and descends one row every ANIM_TICKS clocks (busy is high
// meanwhile). When undefined, a piece lands on the same edge and busy is 0.
module board_state_writer #(
    parameter int START_COL  = 3,
    parameter int ANIM_TICKS = 5000000,
    parameter int CNT_W      = 23
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        move_left,
    input  logic        move_right,
    input  logic        drop,
    input  logic        new_game,
    output logic [2:0]  A,
    output logic        player_colour,
    output logic [11:0] col1,
    output logic [11:0] col2,
    output logic [11:0] col3,
    output logic [11:0] col4,
    output logic [11:0] col5,
    output logic [11:0] col6,
    output logic [11:0] col7,
    output logic        busy,
    output logic        drop_err,
    output logic        board_full,
    output logic [5:0]  move_count
);

    localparam logic [2:0]       START_A   = 3'(START_COL);
    localparam logic [5:0]       MAX_MOVES = 6'd42;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(ANIM_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef DROP_ANIM_EN
        ANIM = 2'd1,
`endif
        OVER = 2'd2
    } state_t;

    // Lowest empty row of a column (only meaningful when the column is not full).
    function automatic logic [2:0] f_target_row(input logic [11:0] col);
        logic [2:0] row;
        row = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (col[2*i +: 2] == 2'b00) begin
                row = 3'(i);
            end else begin
                row = row;
            end
        end
        return row;
    endfunction

    state_t           r_state, w_state_nxt;
    logic [6:0][11:0] r_cols, w_cols_nxt;
    logic [2:0]       r_a, w_a_nxt;
    logic             r_player, w_player_nxt;
    logic [5:0]       r_move_count, w_count_nxt;
    logic             r_board_full, w_full_nxt;
    logic             r_drop_err, w_drop_err_nxt;

    logic [11:0]      w_cur_col;
    logic             w_col_full;
    logic [2:0]       w_tgt_row;
    logic [1:0]       w_cell;
    logic [5:0]       w_count_inc;

    assign w_cur_col   = r_cols[r_a];
    assign w_col_full  = |w_cur_col[11:10];
    assign w_tgt_row   = f_target_row(w_cur_col);
    assign w_cell      = {r_player, ~r_player};
    assign w_count_inc = r_move_count + 6'd1;

`ifdef DROP_ANIM_EN
    logic             r_busy, w_busy_nxt;
    logic [CNT_W-1:0] r_tick, w_tick_nxt;
    logic [2:0]       r_anim_col, w_anim_col_nxt;
    logic [2:0]       r_anim_row, w_anim_row_nxt;
    logic [2:0]       r_anim_tgt, w_anim_tgt_nxt;
    logic [2:0]       w_row_below;

    assign w_row_below = r_anim_row - 3'd1;
`else
    logic w_unused_tick;
    assign w_unused_tick = ^TICK_LAST;
`endif

    // Next-state logic: command priority new_game > drop > cursor moves.
    always_comb begin
        w_state_nxt    = r_state;
        w_cols_nxt     = r_cols;
        w_a_nxt        = r_a;
        w_player_nxt   = r_player;
        w_count_nxt    = r_move_count;
        w_full_nxt     = r_board_full;
        w_drop_err_nxt = 1'b0;
`ifdef DROP_ANIM_EN
        w_busy_nxt     = r_busy;
        w_tick_nxt     = r_tick;
        w_anim_col_nxt = r_anim_col;
        w_anim_row_nxt = r_anim_row;
        w_anim_tgt_nxt = r_anim_tgt;
`endif
        if (new_game) begin
            w_state_nxt  = IDLE;
            w_cols_nxt   = '0;
            w_a_nxt      = START_A;
            w_player_nxt = 1'b0;
            w_count_nxt  = 6'd0;
            w_full_nxt   = 1'b0;
`ifdef DROP_ANIM_EN
            w_busy_nxt   = 1'b0;
            w_tick_nxt   = '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (drop) begin
                        if (w_col_full) begin
                            w_drop_err_nxt = 1'b1;
                        end else begin
`ifdef DROP_ANIM_EN
                            // Piece appears in the top row; the landing row is latched.
                            w_cols_nxt[r_a][11:10] = w_cell;
                            w_busy_nxt     = 1'b1;
                            w_tick_nxt     = '0;
                            w_anim_col_nxt = r_a;
                            w_anim_row_nxt = 3'd5;
                            w_anim_tgt_nxt = w_tgt_row;
                            w_state_nxt    = ANIM;
`else
                            w_cols_nxt[r_a][{w_tgt_row, 1'b0} +: 2] = w_cell;
                            w_player_nxt = ~r_player;
                            w_count_nxt  = w_count_inc;
                            if (w_count_inc == MAX_MOVES) begin
                                w_full_nxt  = 1'b1;
                                w_state_nxt = OVER;
                            end else begin
                                w_state_nxt = IDLE;
                            end
`endif
                        end
                    end else if (move_left && !move_right) begin
                        if (r_a != 3'd0) begin
                            w_a_nxt = r_a - 3'd1;
                        end else begin
                            w_a_nxt = r_a;
                        end
                    end else if (move_right && !move_left) begin
                        if (r_a != 3'd6) begin
                            w_a_nxt = r_a + 3'd1;
                        end else begin
                            w_a_nxt = r_a;
                        end
                    end else begin
                        w_a_nxt = r_a;
                    end
                end
`ifdef DROP_ANIM_EN
                ANIM: begin
                    if (r_tick == TICK_LAST) begin
                        w_tick_nxt = '0;
                        if (r_anim_row != r_anim_tgt) begin
                            // Step the piece down one row on a single edge.
                            w_cols_nxt[r_anim_col][{r_anim_row, 1'b0} +: 2]  = 2'b00;
                            w_cols_nxt[r_anim_col][{w_row_below, 1'b0} +: 2] = w_cell;
                            w_anim_row_nxt = w_row_below;
                        end else begin
                            w_anim_row_nxt = r_anim_row;
                        end
                        if ((r_anim_row == r_anim_tgt) || (w_row_below == r_anim_tgt)) begin
                            w_busy_nxt   = 1'b0;
                            w_player_nxt = ~r_player;
                            w_count_nxt  = w_count_inc;
                            if (w_count_inc == MAX_MOVES) begin
                                w_full_nxt  = 1'b1;
                                w_state_nxt = OVER;
                            end else begin
                                w_state_nxt = IDLE;
                            end
                        end else begin
                            w_state_nxt = ANIM;
                        end
                    end else begin
                        w_tick_nxt = r_tick + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
`endif
                OVER: begin
                    w_state_nxt = OVER;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cols       <= '0;
            r_a          <= START_A;
            r_player     <= 1'b0;
            r_move_count <= 6'd0;
            r_board_full <= 1'b0;
            r_drop_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cols       <= w_cols_nxt;
            r_a          <= w_a_nxt;
            r_player     <= w_player_nxt;
            r_move_count <= w_count_nxt;
            r_board_full <= w_full_nxt;
            r_drop_err   <= w_drop_err_nxt;
        end
    end

`ifdef DROP_ANIM_EN
    // Animation bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= 1'b0;
            r_tick     <= '0;
            r_anim_col <= 3'd0;
            r_anim_row <= 3'd0;
            r_anim_tgt <= 3'd0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_tick     <= w_tick_nxt;
            r_anim_col <= w_anim_col_nxt;
            r_anim_row <= w_anim_row_nxt;
            r_anim_tgt <= w_anim_tgt_nxt;
        end
    end

    assign busy = r_busy;
`else
    assign busy = 1'b0;
`endif

    assign A             = r_a;
    assign player_colour = r_player;
    assign move_count    = r_move_count;
    assign board_full    = r_board_full;
    assign drop_err      = r_drop_err;
    assign col1          = r_cols[0];
    assign col2          = r_cols[1];
    assign col3          = r_cols[2];
    assign col4          = r_cols[3];
    assign col5          = r_cols[4];
    assign col6          = r_cols[5];
    assign col7          = r_cols[6];

endmodule
